// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and constants for the Fibonacci sequencer
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FIB_WIDTH  = 16;
  localparam int FIB_IDX_W  = 5;
  localparam int FIB_SEED_A = 0;
  localparam int FIB_SEED_B = 1;

endpackage

// File: rtl/fib_step_dp.sv
// rtl/fib_step_dp.sv - two-register Fibonacci datapath with sticky overflow
module fib_step_dp
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] a_o,
  output logic             a_ovf_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             a_ovf_q, a_ovf_d;
  logic             b_ovf_q, b_ovf_d;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // a_ovf trails b_ovf by one step, so it always describes the term held in a.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    a_ovf_d = a_ovf_q;
    b_ovf_d = b_ovf_q;
    if (load) begin
      a_d     = WIDTH'(FIB_SEED_A);
      b_d     = WIDTH'(FIB_SEED_B);
      a_ovf_d = 1'b0;
      b_ovf_d = 1'b0;
    end else if (step) begin
      a_d     = b_q;
      b_d     = sum[WIDTH-1:0];
      a_ovf_d = b_ovf_q;
      b_ovf_d = b_ovf_q | a_ovf_q | sum[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= WIDTH'(FIB_SEED_A);
      b_q     <= WIDTH'(FIB_SEED_B);
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      a_ovf_q <= a_ovf_d;
      b_ovf_q <= b_ovf_d;
    end
  end

  assign a_o     = a_q;
  assign a_ovf_o = a_ovf_q;

endmodule

// File: rtl/fib_seq_ctrl.sv
// rtl/fib_seq_ctrl.sv - request/response sequencer computing F(n) on demand
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int IDX_W = FIB_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_n,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_value,
  output logic             rsp_ovf,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_value_q, rsp_value_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             load, step;
  logic [WIDTH-1:0] dp_a;
  logic             dp_a_ovf;

  fib_step_dp #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .a_o     (dp_a),
    .a_ovf_o (dp_a_ovf)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_value_d = rsp_value_q;
    rsp_ovf_d   = rsp_ovf_q;
    load        = 1'b0;
    step        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = req_n;
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          step  = 1'b1;
          cnt_d = cnt_q - IDX_W'(1);
        end else begin
          // a is final here; capture it so the response holds through backpressure.
          rsp_value_d = dp_a;
          rsp_ovf_d   = dp_a_ovf;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_value_q <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_value_q <= rsp_value_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_value = rsp_value_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb/tb_fib_seq_ctrl.sv - self-checking bench for fib_seq_ctrl against an arithmetic Fibonacci model
module tb_fib_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_n;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_value;
  logic        rsp_ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fib_seq_ctrl #(.WIDTH(16), .IDX_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_n     (req_n),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_value (rsp_value),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // True (unbounded) Fibonacci number; the response is this value mod 2^16.
  function automatic longint fib_ref(input int n);
    longint x, y, t;
    x = 0;
    y = 1;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for its response, optionally stall rsp_ready for
  // 'hold' cycles (with a competing req_valid if 'pend'), then handshake.
  task automatic run_req(input int n, input int post_n, input int hold, input bit pend);
    longint      f;
    logic [15:0] ev;
    logic        eo;
    int          k;
    f  = fib_ref(n);
    ev = f[15:0];
    eo = (f >= 65536);
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_n     = 5'(n);
    @(negedge clk);
    req_valid = 1'b0;
    req_n     = 5'(post_n);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    k = 0;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    check($sformatf("latency_n%0d", n), k, n + 1);
    check($sformatf("value_n%0d", n), {16'd0, rsp_value}, {16'd0, ev});
    check($sformatf("ovf_n%0d", n), {31'd0, rsp_ovf}, {31'd0, eo});
    if (pend) begin
      req_valid = 1'b1;
      req_n     = 5'd3;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_value", {16'd0, rsp_value}, {16'd0, ev});
      check("hold_ovf", {31'd0, rsp_ovf}, {31'd0, eo});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("valid_after_handshake", {31'd0, rsp_valid}, 32'd0);
    check("ready_after_handshake", {31'd0, req_ready}, 32'd1);
    check("busy_after_handshake", {31'd0, busy}, 32'd0);
    if (pend) begin
      @(negedge clk);
      req_valid = 1'b0;
      check("pend_accepted_next", {31'd0, busy}, 32'd1);
      k = 0;
      while (!rsp_valid && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("pend_latency", k, 4);
      check("pend_value", {16'd0, rsp_value}, 32'd2);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("pend_done", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_n     = '0;
    rsp_ready = 1'b0;
    #12;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_value", {16'd0, rsp_value}, 32'd0);
    check("rst_rsp_ovf", {31'd0, rsp_ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Small indices and the 16-bit overflow boundary.
    run_req(0, 17, 0, 1'b0);
    run_req(1, 9, 0, 1'b0);
    run_req(2, 31, 0, 1'b0);
    run_req(10, 0, 0, 1'b0);
    run_req(24, 3, 0, 1'b0);
    run_req(25, 1, 0, 1'b0);
    run_req(31, 2, 0, 1'b0);

    // Capture: req_n changes to 30 right after accepting 6.
    run_req(6, 30, 0, 1'b0);

    // Backpressure with a competing request held during DONE.
    run_req(7, 0, 10, 1'b1);

    // Asynchronous reset in the middle of a long run.
    req_valid = 1'b1;
    req_n     = 5'd20;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    check("no_stale_response", {31'd0, rsp_valid}, 32'd0);
    run_req(5, 12, 0, 1'b0);

    // Randomized traffic with idle gaps and response stalls.
    for (int r = 0; r < 200; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_req(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
